// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants, also used by decode and imm_gen.
// Defines are guarded so the decode-side headers can provide them first.
`ifndef NOP_INSTR
`define NOP_INSTR 32'h0000_0013
`endif
`ifndef RESET_VECTOR
`define RESET_VECTOR 32'h0000_0000
`endif

package fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = `NOP_INSTR;
    localparam logic [XLEN-1:0] RESET_VECTOR = `RESET_VECTOR;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, response
// buffer toward decode, and redirect flush with in-flight drop counting.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_VECTOR,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic          rst_q;
    logic [31:0]   pc;
    logic [CW-1:0] drop;
    logic [CW-1:0] drop_next;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] out_next;
    logic [CW-1:0] buf_count;
    logic [CW:0]   in_use;
    logic          req_fire;
    logic          rsp_fire;
    logic          rsp_keep;
    logic          id_pop;
    fetch_entry_t  buf_head;
    fetch_entry_t  buf_in;
    logic [31:0]   pcq_head;
    logic          buf_empty;
    logic          buf_full;
    logic          pcq_empty;
    logic          pcq_full;
    logic          unused_ok;

    assign unused_ok = buf_full ^ pcq_full;

    // Credit covers both buffered and in-flight words, so the buffer never overflows.
    assign in_use = {1'b0, buf_count} + {1'b0, outstanding};

    assign imem_req_valid = !rst_q && !redirect_valid
                          && (in_use < (CW + 1)'(BUF_DEPTH));
    assign imem_req_addr  = pc;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_fire = imem_rsp_valid && !pcq_empty;
    assign rsp_keep = rsp_fire && (drop == '0) && !redirect_valid;
    assign id_pop   = id_valid && id_ready;
    assign out_next = outstanding + CW'(req_fire) - CW'(rsp_fire);

    assign buf_in = '{instr: imem_rsp_data, pc: pcq_head};

    always_comb begin
        drop_next = drop;
        if (redirect_valid) begin
            drop_next = out_next;
        end else if (rsp_fire && (drop != '0)) begin
            drop_next = drop - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_q <= 1'b1;
            pc    <= RESET_PC;
            drop  <= '0;
        end else begin
            rst_q <= 1'b0;
            drop  <= drop_next;
            if (redirect_valid) begin
                pc <= word_align(redirect_pc);
            end else if (req_fire) begin
                pc <= pc + 32'd4;
            end
        end
    end

    // The PC queue is never flushed: dropped responses still retire their entry.
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (BUF_DEPTH)
    ) u_pcq (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (pc),
        .pop       (rsp_fire),
        .head      (pcq_head),
        .count     (outstanding),
        .empty     (pcq_empty),
        .full      (pcq_full)
    );

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (BUF_DEPTH)
    ) u_ibuf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data (buf_in),
        .pop       (id_pop),
        .head      (buf_head),
        .count     (buf_count),
        .empty     (buf_empty),
        .full      (buf_full)
    );

    assign id_valid = !buf_empty;
    assign id_instr = id_valid ? buf_head.instr : NOP_INSTR;
    assign id_pc    = id_valid ? buf_head.pc : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed tables and sequences plus
// randomized traffic against an epoch-tagged reference model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int          BD  = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    fetch_unit #(
        .RESET_PC  (RPC),
        .BUF_DEPTH (BD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] mpc;
        int          due;
        int          epoch;
        bit          live;
    } mreq_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        bit          rv;
        logic [31:0] addr;
        bit          idv;
        logic [31:0] pc;
    } vec_t;

    mreq_t       mq[$];
    ent_t        bq[$];
    vec_t        tv[9];
    logic [31:0] m_pc;
    int          epoch;
    bit          m_first;
    int          cyc;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          rsp_pct = 100;
    int          checks = 0;
    int          errors = 0;

    bit          s_rv, s_acc, s_idv, s_pop;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] word(input logic [31:0] a);
        return ((a ^ 32'hC0DE_0000) * 32'h0001_0003) + 32'h0000_0013;
    endfunction

    function automatic int count_live();
        int n = 0;
        foreach (mq[i]) if (mq[i].live) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, advance the model,
    // then drive the memory response for the next cycle.
    task automatic tick();
        bit          e_rv, dlv, kept, pop, r_v;
        logic [31:0] r_pc;
        int          lat;
        @(negedge clk);
        e_rv = !m_first && !redirect_valid && ((bq.size() + count_live()) < BD);
        s_rv    = imem_req_valid;
        s_acc   = imem_req_valid && imem_req_ready;
        s_addr  = imem_req_addr;
        s_idv   = id_valid;
        s_pc    = id_pc;
        s_instr = id_instr;
        s_pop   = id_valid && id_ready;
        r_v     = redirect_valid;
        r_pc    = redirect_pc;
        chk("m_req_valid", s_rv, e_rv);
        if (e_rv) chk("m_req_addr", s_addr, m_pc);
        chk("m_id_valid", s_idv, bq.size() != 0);
        if (bq.size() != 0) begin
            chk("m_id_pc", s_pc, bq[0].pc);
            chk("m_id_instr", s_instr, bq[0].instr);
        end else begin
            chk("m_id_pc_idle", s_pc, 32'h0);
            chk("m_id_instr_idle", s_instr, NOP_INSTR);
        end
        dlv  = imem_rsp_valid && (mq.size() != 0);
        kept = dlv && mq[0].live && (mq[0].epoch == epoch) && !r_v;
        pop  = (bq.size() != 0) && id_ready;
        if (kept) begin
            checks++;
            if (bq.size() - int'(pop) >= BD) begin
                errors++;
                $display("FAIL overflow actual=%0d required<%0d", bq.size(), BD);
            end
        end
        @(posedge clk);
        cyc++;
        if (pop) void'(bq.pop_front());
        if (kept) bq.push_back('{instr: word(mq[0].mpc), pc: mq[0].mpc});
        if (dlv) void'(mq.pop_front());
        if (s_acc) begin
            lat = lat_lo + int'($urandom_range(0, lat_hi - lat_lo));
            mq.push_back('{addr: s_addr, mpc: m_pc, due: cyc - 1 + lat,
                           epoch: epoch, live: 1'b1});
        end
        if (r_v) begin
            bq.delete();
            epoch++;
            m_pc = {r_pc[31:2], 2'b00};
        end else if (s_acc) begin
            m_pc = m_pc + 32'd4;
        end
        m_first = 1'b0;
        #1;
        if (mq.size() != 0 && mq[0].due <= cyc
            && int'($urandom_range(0, 99)) < rsp_pct) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic wait_pop(input string name, input logic [31:0] exp);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (s_pop) begin
                chk(name, s_pc, exp);
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s timeout actual=none required=%h", name, exp);
    endtask

    task automatic wait_req(input string name, input logic [31:0] exp);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (s_acc) begin
                chk(name, s_addr, exp);
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s timeout actual=none required=%h", name, exp);
    endtask

    task automatic run_table(input string tag);
        lat_lo = 1;
        lat_hi = 1;
        rsp_pct = 100;
        imem_req_ready = 1'b1;
        id_ready = 1'b1;
        redirect_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("%s_rv%0d", tag, i), s_rv, tv[i].rv);
            if (tv[i].rv) chk($sformatf("%s_addr%0d", tag, i), s_addr, tv[i].addr);
            chk($sformatf("%s_idv%0d", tag, i), s_idv, tv[i].idv);
            if (tv[i].idv) begin
                chk($sformatf("%s_pc%0d", tag, i), s_pc, tv[i].pc);
                chk($sformatf("%s_ins%0d", tag, i), s_instr, word(tv[i].pc));
            end else begin
                chk($sformatf("%s_nop%0d", tag, i), s_instr, NOP_INSTR);
            end
        end
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc = target;
        tick();
        chk("redir_rv_low", s_rv, 1'b0);
        redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        bit found;
        logic [31:0] held;
        int nacc;

        // Cycle-by-cycle expectation after reset with 1-cycle memory
        tv[0] = '{1'b0, 32'h0,  1'b0, 32'h0};
        tv[1] = '{1'b1, 32'h0,  1'b0, 32'h0};
        tv[2] = '{1'b1, 32'h4,  1'b0, 32'h0};
        tv[3] = '{1'b0, 32'h0,  1'b1, 32'h0};
        tv[4] = '{1'b1, 32'h8,  1'b1, 32'h4};
        tv[5] = '{1'b1, 32'hC,  1'b0, 32'h0};
        tv[6] = '{1'b0, 32'h0,  1'b1, 32'h8};
        tv[7] = '{1'b1, 32'h10, 1'b1, 32'hC};
        tv[8] = '{1'b1, 32'h14, 1'b0, 32'h0};

        rst = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        id_ready = 1'b1;
        #1;
        chk("reset_idv", id_valid, 1'b0);
        chk("reset_rv", imem_req_valid, 1'b0);
        chk("reset_instr", id_instr, NOP_INSTR);
        chk("reset_pc", id_pc, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_pc = RPC;
        m_first = 1'b1;
        epoch = 0;
        cyc = 0;

        run_table("t1");

        // Stall decode for 10 cycles
        id_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = s_idv;
        end
        chk("stall_found", found, 1'b1);
        held = s_pc;
        nacc = int'(s_acc);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("stall_valid", s_idv, 1'b1);
            chk("stall_pc", s_pc, held);
            chk("stall_instr", s_instr, word(held));
            nacc += int'(s_acc);
        end
        chk("stall_credit", nacc <= BD, 1'b1);
        id_ready = 1'b1;
        wait_pop("stall_rel0", held);
        wait_pop("stall_rel1", held + 32'd4);

        // Redirect with two requests outstanding
        lat_lo = 3;
        lat_hi = 3;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            found = (count_live() == 2);
        end
        chk("t3_two_out", found, 1'b1);
        redirect_to(32'h0000_0100);
        wait_pop("t3_first", 32'h0000_0100);
        wait_pop("t3_second", 32'h0000_0104);

        // Redirect while a response arrives and another request is in flight
        lat_lo = 2;
        lat_hi = 2;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            found = imem_rsp_valid && (count_live() >= 2);
        end
        chk("t4_setup", found, 1'b1);
        redirect_to(32'h0000_0300);
        wait_pop("t4_first", 32'h0000_0300);
        wait_pop("t4_second", 32'h0000_0304);

        // Misaligned target and PC wrap
        lat_lo = 1;
        lat_hi = 1;
        redirect_to(32'h0000_0203);
        wait_req("t5_align_req", 32'h0000_0200);
        wait_pop("t5_align_pop", 32'h0000_0200);
        redirect_to(32'hFFFF_FFFE);
        wait_req("t5_top_req", 32'hFFFF_FFFC);
        wait_req("t5_wrap_req", 32'h0000_0000);
        wait_pop("t5_top_pop", 32'hFFFF_FFFC);
        wait_pop("t5_wrap_pop", 32'h0000_0000);

        // Randomized traffic against the model
        lat_lo = 1;
        lat_hi = 4;
        rsp_pct = 70;
        for (int i = 0; i < 600; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            id_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 29) == 0);
            redirect_pc = $urandom;
            tick();
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        id_ready = 1'b1;

        // Reset mid-stream with a response on the bus
        lat_lo = 1;
        lat_hi = 1;
        rsp_pct = 100;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            found = imem_rsp_valid && (mq.size() == 1);
        end
        chk("t6_pending", found, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_idv", id_valid, 1'b0);
        chk("t6_rv", imem_req_valid, 1'b0);
        chk("t6_instr", id_instr, NOP_INSTR);
        chk("t6_pc", id_pc, 32'h0);
        bq.delete();
        foreach (mq[i]) mq[i].live = 1'b0;
        m_pc = RPC;
        m_first = 1'b1;
        rst = 1'b0;
        run_table("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
